// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl
// Description : Pipeline interlock controller around the decode stage.
//               A shift-register scoreboard tracks the destination register
//               (and load flag) of every instruction still in EX, MEM or WB.
//               RAW hazards on the decoding instruction stall IA and IF/ID
//               and inject ID/EX bubbles. A busy MEM stage freezes the whole
//               pipe. A taken branch flushes its fetched successor.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Optional feature macro: HAZARD_CTRL_FORWARD_EN
//   defined   : only load-use hazards stall (one bubble); EX forwarding
//               selects point at the youngest matching scoreboard entry.
//   undefined : any in-flight writer stalls the reader until it leaves WB;
//               forwarding selects are tied to 0 (register file).
// ----------------------------------------------------------------------------
// Ports
//   clk            in   clock
//   rst            in   synchronous reset, active-high
//   id_valid       in   IF/ID holds a valid instruction
//   id_ra_addr     in   decoded ra address           id_ra_used  in  reads ra
//   id_rb_addr     in   decoded rb address           id_rb_used  in  reads rb
//   id_rd_addr     in   destination (0 = no write)   id_is_load  in  is a load
//   id_branch_req  in   ID resolved a BRA/CALL
//   mem_busy       in   MEM data access incomplete this cycle
//   ifid_stall     out  hold IA and IF/ID
//   ifid_flush     out  clear IF/ID to a bubble at the next edge
//   idex_bubble    out  load a NOP into ID/EX
//   pipe_freeze    out  hold ID/EX, EX/MEM, MEM/WB
//   fwd_a_sel      out  ra source for EX: 0 = regfile, k = scoreboard entry k
//   fwd_b_sel      out  rb source, same encoding
//   stall_cycles   out  saturating count of cycles with ifid_stall=1
// ============================================================================
module hazard_ctrl #(
    parameter int PIPE_DEPTH  = 3,
    parameter int STALL_CNT_W = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            id_valid,
    input  logic [4:0]                      id_ra_addr,
    input  logic                            id_ra_used,
    input  logic [4:0]                      id_rb_addr,
    input  logic                            id_rb_used,
    input  logic [4:0]                      id_rd_addr,
    input  logic                            id_is_load,
    input  logic                            id_branch_req,
    input  logic                            mem_busy,
    output logic                            ifid_stall,
    output logic                            ifid_flush,
    output logic                            idex_bubble,
    output logic                            pipe_freeze,
    output logic [$clog2(PIPE_DEPTH+1)-1:0] fwd_a_sel,
    output logic [$clog2(PIPE_DEPTH+1)-1:0] fwd_b_sel,
    output logic [STALL_CNT_W-1:0]          stall_cycles
);

    localparam int SEL_W = $clog2(PIPE_DEPTH + 1);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_STALL  = 2'd1,
        ST_FREEZE = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Scoreboard entry k holds the instruction k stages past ID
    // (1 = EX, 2 = MEM, 3 = WB for the default depth).
    logic [PIPE_DEPTH:1][4:0] sb_rd_q, sb_rd_d;
    logic [PIPE_DEPTH:1]      sb_ld_q, sb_ld_d;

    logic [STALL_CNT_W-1:0]   stall_cnt_q;

    logic [PIPE_DEPTH:1]      w_match_a;
    logic [PIPE_DEPTH:1]      w_match_b;
    logic                     w_hazard;
    logic                     w_issue;
    logic                     w_unused_ld;

    // ------------------------------------------------------------------
    // Per-entry operand match; register 0 is hard-wired and never hazards.
    // ------------------------------------------------------------------
    for (genvar k = 1; k <= PIPE_DEPTH; k++) begin : g_match
        assign w_match_a[k] = id_ra_used && (id_ra_addr != 5'd0) && (id_ra_addr == sb_rd_q[k]);
        assign w_match_b[k] = id_rb_used && (id_rb_addr != 5'd0) && (id_rb_addr == sb_rd_q[k]);
    end

`ifdef HAZARD_CTRL_FORWARD_EN
    // Results in EX..WB can be forwarded, except a load still in EX whose
    // data does not exist yet: that costs exactly one bubble.
    assign w_hazard = id_valid && sb_ld_q[1] && (w_match_a[1] || w_match_b[1]);

    // Youngest producer wins, so scan from the oldest entry down and let
    // the smaller index overwrite.
    always_comb begin
        fwd_a_sel = '0;
        fwd_b_sel = '0;
        for (int k = PIPE_DEPTH; k >= 1; k--) begin
            if (w_match_a[k]) begin
                fwd_a_sel = SEL_W'(k);
            end
            if (w_match_b[k]) begin
                fwd_b_sel = SEL_W'(k);
            end
        end
    end
`else
    // Without forwarding the reader waits until the writer has left WB.
    assign w_hazard  = id_valid && ((|w_match_a) || (|w_match_b));
    assign fwd_a_sel = '0;
    assign fwd_b_sel = '0;
`endif

    // Load flags only influence load-use detection in EX; the remaining
    // entries exist just to carry the flag down the pipe.
    assign w_unused_ld = ^sb_ld_q;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next state. mem_busy dominates; a stall lasts exactly as long as the
    // hazard, so leaving STALL or FREEZE costs no extra dead cycle.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (mem_busy) begin
                    state_d = ST_FREEZE;
                end else if (w_hazard) begin
                    state_d = ST_STALL;
                end
            end
            ST_STALL: begin
                if (mem_busy) begin
                    state_d = ST_FREEZE;
                end else if (!w_hazard) begin
                    state_d = ST_RUN;
                end
            end
            ST_FREEZE: begin
                if (!mem_busy) begin
                    state_d = w_hazard ? ST_STALL : ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs decode the state the pipe is in during this cycle (state_d),
    // because a busy MEM or a hazard must hold the pipe in the same cycle.
    // A branch seen while stalled or frozen stays in IF/ID and flushes once
    // the stall is released.
    // ------------------------------------------------------------------
    always_comb begin
        pipe_freeze = 1'b0;
        ifid_stall  = 1'b0;
        idex_bubble = 1'b0;
        case (state_d)
            ST_FREEZE: begin
                pipe_freeze = 1'b1;
                ifid_stall  = 1'b1;
            end
            ST_STALL: begin
                ifid_stall  = 1'b1;
                idex_bubble = 1'b1;
            end
            default: begin
                pipe_freeze = 1'b0;
            end
        endcase
        ifid_flush = id_valid && id_branch_req && !ifid_stall;
    end

    // The branch itself moves on into ID/EX (a CALL writes r31 and must be
    // tracked); only the successor being fetched is flushed.
    assign w_issue = id_valid && !ifid_stall;

    // ------------------------------------------------------------------
    // Scoreboard shift
    // ------------------------------------------------------------------
    always_comb begin
        sb_rd_d = sb_rd_q;
        sb_ld_d = sb_ld_q;
        for (int k = PIPE_DEPTH; k >= 2; k--) begin
            sb_rd_d[k] = sb_rd_q[k-1];
            sb_ld_d[k] = sb_ld_q[k-1];
        end
        sb_rd_d[1] = w_issue ? id_rd_addr : 5'd0;
        sb_ld_d[1] = w_issue && id_is_load;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sb_rd_q <= '0;
            sb_ld_q <= '0;
        end else if (!pipe_freeze) begin
            sb_rd_q <= sb_rd_d;
            sb_ld_q <= sb_ld_d;
        end
    end

    // ------------------------------------------------------------------
    // Saturating stall-cycle counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if (ifid_stall && (stall_cnt_q != {STALL_CNT_W{1'b1}})) begin
            stall_cnt_q <= stall_cnt_q + STALL_CNT_W'(1);
        end
    end

    assign stall_cycles = stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_ctrl
// Description : Self-checking bench for hazard_ctrl (PIPE_DEPTH=3). Each
//               scenario queues its stimulus with the hand-derived outputs
//               expected in that cycle; the expectation is pushed to the
//               scoreboard when the stimulus is driven and popped when the
//               DUT outputs are sampled on the falling edge.
//               Honours HAZARD_CTRL_FORWARD_EN like the design.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [4:0]  id_ra_addr;
    logic        id_ra_used;
    logic [4:0]  id_rb_addr;
    logic        id_rb_used;
    logic [4:0]  id_rd_addr;
    logic        id_is_load;
    logic        id_branch_req;
    logic        mem_busy;
    logic        ifid_stall;
    logic        ifid_flush;
    logic        idex_bubble;
    logic        pipe_freeze;
    logic [1:0]  fwd_a_sel;
    logic [1:0]  fwd_b_sel;
    logic [15:0] stall_cycles;

    always #5 clk = ~clk;

    hazard_ctrl #(
        .PIPE_DEPTH  (3),
        .STALL_CNT_W (16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .id_valid      (id_valid),
        .id_ra_addr    (id_ra_addr),
        .id_ra_used    (id_ra_used),
        .id_rb_addr    (id_rb_addr),
        .id_rb_used    (id_rb_used),
        .id_rd_addr    (id_rd_addr),
        .id_is_load    (id_is_load),
        .id_branch_req (id_branch_req),
        .mem_busy      (mem_busy),
        .ifid_stall    (ifid_stall),
        .ifid_flush    (ifid_flush),
        .idex_bubble   (idex_bubble),
        .pipe_freeze   (pipe_freeze),
        .fwd_a_sel     (fwd_a_sel),
        .fwd_b_sel     (fwd_b_sel),
        .stall_cycles  (stall_cycles)
    );

    typedef struct packed {
        logic       r;
        logic       v;
        logic [4:0] rd;
        logic [4:0] ra;
        logic [4:0] rb;
        logic [1:0] u;    // {ra_used, rb_used}
        logic       ld;
        logic       br;
        logic       mb;
    } stim_t;

    typedef struct packed {
        logic       stall;
        logic       flush;
        logic       bubble;
        logic       freeze;
        logic [1:0] fa;
        logic [1:0] fb;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

`ifdef HAZARD_CTRL_FORWARD_EN
    localparam logic [1:0] F1 = 2'd1;
`else
    localparam logic [1:0] F1 = 2'd0;
`endif

    function automatic stim_t stim(input logic v, input logic [4:0] rd, input logic [4:0] ra,
                                   input logic [4:0] rb, input logic [1:0] u, input logic ld,
                                   input logic br, input logic mb, input logic r);
        stim_t s;
        s.v = v; s.rd = rd; s.ra = ra; s.rb = rb; s.u = u;
        s.ld = ld; s.br = br; s.mb = mb; s.r = r;
        return s;
    endfunction

    function automatic stim_t idle();
        return stim(1'b0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    endfunction

    function automatic exp_t expv(input logic stall, input logic flush, input logic bubble,
                                  input logic freeze, input logic [1:0] fa, input logic [1:0] fb);
        exp_t e;
        e.stall = stall; e.flush = flush; e.bubble = bubble;
        e.freeze = freeze; e.fa = fa; e.fb = fb;
        return e;
    endfunction

    task automatic apply(input stim_t s);
        rst           = s.r;
        id_valid      = s.v;
        id_rd_addr    = s.rd;
        id_ra_addr    = s.ra;
        id_rb_addr    = s.rb;
        id_ra_used    = s.u[1];
        id_rb_used    = s.u[0];
        id_is_load    = s.ld;
        id_branch_req = s.br;
        mem_busy      = s.mb;
    endtask

    // Clears the pipe; called and returns just after a rising edge.
    task automatic pipe_reset();
        apply(idle());
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        exp_t got, want;
        for (int i = 0; i < 2; i++) begin
            rst           = 1'b1;
            id_valid      = 1'($urandom_range(0, 1));
            id_ra_addr    = 5'($urandom_range(0, 31));
            id_ra_used    = 1'($urandom_range(0, 1));
            id_rb_addr    = 5'($urandom_range(0, 31));
            id_rb_used    = 1'($urandom_range(0, 1));
            id_rd_addr    = 5'($urandom_range(0, 31));
            id_is_load    = 1'($urandom_range(0, 1));
            id_branch_req = 1'($urandom_range(0, 1));
            mem_busy      = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(expv(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0));
            apply(idle());
            @(negedge clk);
            want = exp_q.pop_front();
            got  = {ifid_stall, ifid_flush, idex_bubble, pipe_freeze, fwd_a_sel, fwd_b_sel};
            n_checks++;
            if (got !== want) begin
                n_errors++;
                $display("FAIL reset_outputs cycle %0d: got %b expected %b", i, got, want);
            end
            n_checks++;
            if (stall_cycles !== 16'd0) begin
                n_errors++;
                $display("FAIL reset_stall_cycles cycle %0d: got %0d expected 0", i, stall_cycles);
            end
            @(posedge clk); #1;
        end
    endtask

    // ------------------------------------------------------------------
    // ADD r5 then a reader of r5: waits until r5 leaves WB (3 cycles).
    task automatic test_raw_stall();
        stim_t sq[$];
        exp_t  eq[$];
        exp_t  got, want;
        int    step = 0;
        stim_t p5 = stim(1'b1, 5'd5, 5'd1, 5'd2, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        stim_t c5 = stim(1'b1, 5'd6, 5'd5, 5'd1, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        stim_t nu = stim(1'b1, 5'd10, 5'd6, 5'd6, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        pipe_reset();
        sq.push_back(p5);     eq.push_back(expv(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0));
        for (int i = 0; i < 3; i++) begin
            sq.push_back(c5); eq.push_back(expv(1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0));
        end
        sq.push_back(c5);     eq.push_back(expv(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0));
        sq.push_back(nu);     eq.push_back(expv(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0));
        sq.push_back(idle()); eq.push_back(expv(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0));
        while (sq.size() > 0) begin
            apply(sq.pop_front());
            exp_q.push_back(eq.pop_front());
            @(negedge clk);
            want = exp_q.pop_front();
            got  = {ifid_stall, ifid_flush, idex_bubble, pipe_freeze, fwd_a_sel, fwd_b_sel};
            n_checks++;
            if (got !== want) begin
                n_errors++;
                $display("FAIL raw_stall step %0d: got %b expected %b", step, got, want);
            end
            step++;
            @(posedge clk); #1;
        end
        n_checks++;
        if (stall_cycles !== 16'd3) begin
            n_errors++;
            $display("FAIL raw_stall_count: got %0d expected 3", stall_cycles);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_reg_zero();
        stim_t sq[$];
        exp_t  eq[$];
        exp_t  got, want;
        int    step = 0;
        pipe_reset();
        sq.push_back(stim(1'b1, 5'd0, 5'd1, 5'd2, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0));
        eq.push_back(expv(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0));
        sq.push_back(stim(1'b1, 5'd7, 5'd0, 5'd0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0));
        eq.push_back(expv(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0));
        sq.push_back(idle());
        eq.push_back(expv(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0));
        while (sq.size() > 0) begin
            apply(sq.pop_front());
            exp_q.push_back(eq.pop_front());
            @(negedge clk);
            want = exp_q.pop_front();
            got  = {ifid_stall, ifid_flush, idex_bubble, pipe_freeze, fwd_a_sel, fwd_b_sel};
            n_checks++;
            if (got !== want) begin
                n_errors++;
                $display("FAIL reg_zero step %0d: got %b expected %b", step, got, want);
            end
            step++;
            @(posedge clk); #1;
        end
        n_checks++;
        if (stall_cycles !== 16'd0) begin
            n_errors++;
            $display("FAIL reg_zero_count: got %0d expected 0", stall_cycles);
        end
    endtask

    // ------------------------------------------------------------------
    // LW r5, then a reader of r5 while MEM is busy for 4 cycles.
    task automatic test_freeze();
        stim_t sq[$];
        exp_t  eq[$];
        exp_t  got, want;
        int    step = 0;
        stim_t l5 = stim(1'b1, 5'd5, 5'd1, 5'd2, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0);
        stim_t cf = stim(1'b1, 5'd6, 5'd5, 5'd1, 2'b11, 1'b0, 1'b0, 1'b1, 1'b0);
        stim_t c5 = stim(1'b1, 5'd6, 5'd5, 5'd1, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        pipe_reset();
        sq.push_back(l5);     eq.push_back(expv(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0));
        for (int i = 0; i < 4; i++) begin
            sq.push_back(cf); eq.push_back(expv(1'b1, 1'b0, 1'b0, 1'b1, F1, 2'd0));
        end
`ifdef HAZARD_CTRL_FORWARD_EN
        sq.push_back(c5);     eq.push_back(expv(1'b1, 1'b0, 1'b1, 1'b0, 2'd1, 2'd0));
        sq.push_back(c5);     eq.push_back(expv(1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 2'd0));
`else
        for (int i = 0; i < 3; i++) begin
            sq.push_back(c5); eq.push_back(expv(1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0));
        end
        sq.push_back(c5);     eq.push_back(expv(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0));
`endif
        sq.push_back(idle()); eq.push_back(expv(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0));
        while (sq.size() > 0) begin
            apply(sq.pop_front());
            exp_q.push_back(eq.pop_front());
            @(negedge clk);
            want = exp_q.pop_front();
            got  = {ifid_stall, ifid_flush, idex_bubble, pipe_freeze, fwd_a_sel, fwd_b_sel};
            n_checks++;
            if (got !== want) begin
                n_errors++;
                $display("FAIL freeze step %0d: got %b expected %b", step, got, want);
            end
            step++;
            @(posedge clk); #1;
        end
        n_checks++;
`ifdef HAZARD_CTRL_FORWARD_EN
        if (stall_cycles !== 16'd5) begin
            n_errors++;
            $display("FAIL freeze_count: got %0d expected 5", stall_cycles);
        end
`else
        if (stall_cycles !== 16'd7) begin
            n_errors++;
            $display("FAIL freeze_count: got %0d expected 7", stall_cycles);
        end
`endif
    endtask

    // ------------------------------------------------------------------
    // CALL (rd=31) held by a busy MEM, flushed after release; a later
    // branch reading r31 must see the CALL's write.
    task automatic test_branch_defer();
        stim_t sq[$];
        exp_t  eq[$];
        exp_t  got, want;
        int    step = 0;
        stim_t bf = stim(1'b1, 5'd31, 5'd0, 5'd0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0);
        stim_t b  = stim(1'b1, 5'd31, 5'd0, 5'd0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
        stim_t rr = stim(1'b1, 5'd8, 5'd3, 5'd31, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0);
        pipe_reset();
        sq.push_back(bf);     eq.push_back(expv(1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0));
        sq.push_back(bf);     eq.push_back(expv(1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0));
        sq.push_back(b);      eq.push_back(expv(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0));
        sq.push_back(idle()); eq.push_back(expv(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0));
`ifdef HAZARD_CTRL_FORWARD_EN
        sq.push_back(rr);     eq.push_back(expv(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd2));
`else
        sq.push_back(rr);     eq.push_back(expv(1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0));
        sq.push_back(rr);     eq.push_back(expv(1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0));
        sq.push_back(rr);     eq.push_back(expv(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0));
`endif
        sq.push_back(idle()); eq.push_back(expv(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0));
        while (sq.size() > 0) begin
            apply(sq.pop_front());
            exp_q.push_back(eq.pop_front());
            @(negedge clk);
            want = exp_q.pop_front();
            got  = {ifid_stall, ifid_flush, idex_bubble, pipe_freeze, fwd_a_sel, fwd_b_sel};
            n_checks++;
            if (got !== want) begin
                n_errors++;
                $display("FAIL branch_defer step %0d: got %b expected %b", step, got, want);
            end
            step++;
            @(posedge clk); #1;
        end
        n_checks++;
`ifdef HAZARD_CTRL_FORWARD_EN
        if (stall_cycles !== 16'd2) begin
            n_errors++;
            $display("FAIL branch_count: got %0d expected 2", stall_cycles);
        end
`else
        if (stall_cycles !== 16'd4) begin
            n_errors++;
            $display("FAIL branch_count: got %0d expected 4", stall_cycles);
        end
`endif
    endtask

    // ------------------------------------------------------------------
    // Reset during a stall empties the scoreboard; the consumer then issues.
    task automatic test_reset_mid_stall();
        stim_t sq[$];
        exp_t  eq[$];
        exp_t  got, want;
        int    step = 0;
        stim_t l5 = stim(1'b1, 5'd5, 5'd1, 5'd2, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0);
        stim_t c5 = stim(1'b1, 5'd6, 5'd5, 5'd1, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        stim_t cr = stim(1'b1, 5'd6, 5'd5, 5'd1, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1);
        pipe_reset();
        sq.push_back(l5);     eq.push_back(expv(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0));
`ifndef HAZARD_CTRL_FORWARD_EN
        sq.push_back(c5);     eq.push_back(expv(1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0));
`endif
        sq.push_back(cr);     eq.push_back(expv(1'b1, 1'b0, 1'b1, 1'b0, F1, 2'd0));
        sq.push_back(c5);     eq.push_back(expv(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0));
        sq.push_back(idle()); eq.push_back(expv(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0));
        while (sq.size() > 0) begin
            apply(sq.pop_front());
            exp_q.push_back(eq.pop_front());
            @(negedge clk);
            want = exp_q.pop_front();
            got  = {ifid_stall, ifid_flush, idex_bubble, pipe_freeze, fwd_a_sel, fwd_b_sel};
            n_checks++;
            if (got !== want) begin
                n_errors++;
                $display("FAIL reset_mid_stall step %0d: got %b expected %b", step, got, want);
            end
            step++;
            @(posedge clk); #1;
        end
        n_checks++;
        if (stall_cycles !== 16'd0) begin
            n_errors++;
            $display("FAIL reset_mid_stall_count: got %0d expected 0", stall_cycles);
        end
    endtask

`ifdef HAZARD_CTRL_FORWARD_EN
    // ------------------------------------------------------------------
    // ADD r5 -> ADD r6,r5 forwards from EX; LW r7 -> reader costs one bubble.
    task automatic test_forwarding();
        stim_t sq[$];
        exp_t  eq[$];
        exp_t  got, want;
        int    step = 0;
        stim_t c2 = stim(1'b1, 5'd9, 5'd7, 5'd6, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        pipe_reset();
        sq.push_back(stim(1'b1, 5'd5, 5'd1, 5'd2, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0));
        eq.push_back(expv(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0));
        sq.push_back(stim(1'b1, 5'd6, 5'd5, 5'd1, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0));
        eq.push_back(expv(1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 2'd0));
        sq.push_back(stim(1'b1, 5'd7, 5'd5, 5'd2, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0));
        eq.push_back(expv(1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 2'd0));
        sq.push_back(c2);
        eq.push_back(expv(1'b1, 1'b0, 1'b1, 1'b0, 2'd1, 2'd2));
        sq.push_back(c2);
        eq.push_back(expv(1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 2'd3));
        sq.push_back(idle());
        eq.push_back(expv(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0));
        while (sq.size() > 0) begin
            apply(sq.pop_front());
            exp_q.push_back(eq.pop_front());
            @(negedge clk);
            want = exp_q.pop_front();
            got  = {ifid_stall, ifid_flush, idex_bubble, pipe_freeze, fwd_a_sel, fwd_b_sel};
            n_checks++;
            if (got !== want) begin
                n_errors++;
                $display("FAIL forwarding step %0d: got %b expected %b", step, got, want);
            end
            step++;
            @(posedge clk); #1;
        end
        n_checks++;
        if (stall_cycles !== 16'd1) begin
            n_errors++;
            $display("FAIL forwarding_count: got %0d expected 1", stall_cycles);
        end
    endtask
`endif

    // ------------------------------------------------------------------
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected run completion");
        $fatal(1, "tb_hazard_ctrl: watchdog expired");
    end

    initial begin
        apply(idle());
        rst = 1'b1;
        @(posedge clk); #1;
        test_reset();
`ifdef HAZARD_CTRL_FORWARD_EN
        test_forwarding();
`else
        test_raw_stall();
`endif
        test_reg_zero();
        test_freeze();
        test_branch_defer();
        test_reset_mid_stall();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
